// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetcher with a DEPTH-entry queue toward decode
//
// Purpose: keeps a running fetch PC, issues one instruction bus request at a
// time, and buffers returned words in a circular FIFO that decode drains with
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetch. A
// response that is still in flight when the redirect arrives is squashed.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   ireq_valid     bus request valid (held until iresp_data_ok)
//   ireq_addr      bus request address (held until iresp_data_ok)
//   iresp_addr_ok  bus address accept (not used by this fetcher)
//   iresp_data_ok  bus response valid, completes the outstanding request
//   iresp_data     bus response instruction word
//   redirect_valid flush the queue and restart fetch at redirect_pc
//   redirect_pc    new fetch target (4-byte aligned)
//   out_valid      head entry valid
//   out_ready      decode accepts the head this cycle
//   out_pc         PC of the head instruction
//   out_inst       head instruction word
//   count          current FIFO occupancy
module fetch_queue #(
  parameter int                DEPTH      = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                INST_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ireq_valid,
  output logic [ADDR_W-1:0]      ireq_addr,
  input  logic                   iresp_addr_ok,
  input  logic                   iresp_data_ok,
  input  logic [31:0]            iresp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state;
  logic              squash;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];

  logic              push;
  logic              pop;
  logic [CW-1:0]     count_after;
  logic              room;

  // Address acceptance carries no information for a single-outstanding fetcher.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp_addr_ok;

  assign ireq_addr = req_pc;
  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[head];
  assign out_inst  = inst_mem[head];

  // A redirect in the same cycle wins over both FIFO ports.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = (state == S_REQ) && iresp_data_ok && !squash && !redirect_valid;

  // Occupancy after this cycle's push/pop; a new request is only started
  // when that leaves a free slot, so its response can always be pushed.
  always_comb begin
    count_after = count;
    if (push && !pop) begin
      count_after = count + 1'b1;
    end else if (pop && !push) begin
      count_after = count - 1'b1;
    end
  end

  assign room = (count_after < CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ireq_valid <= 1'b0;
      squash     <= 1'b0;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else if (redirect_valid) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
      if (state == S_REQ && !iresp_data_ok) begin
        // A bus request is never withdrawn: keep valid/addr and drop its data later.
        squash <= 1'b1;
      end else begin
        state      <= S_IDLE;
        ireq_valid <= 1'b0;
        squash     <= 1'b0;
      end
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count_after;

      if (state == S_IDLE) begin
        if (room) begin
          state      <= S_REQ;
          ireq_valid <= 1'b1;
          req_pc     <= fetch_pc;
        end
      end else if (iresp_data_ok) begin
        if (squash) begin
          squash     <= 1'b0;
          state      <= S_IDLE;
          ireq_valid <= 1'b0;
        end else begin
          fetch_pc <= req_pc + ADDR_W'(INST_BYTES);
          if (room) begin
            // Back-to-back: next sequential request starts right away.
            req_pc <= req_pc + ADDR_W'(INST_BYTES);
          end else begin
            state      <= S_IDLE;
            ireq_valid <= 1'b0;
          end
        end
      end
    end
  end

  // Entry storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= req_pc;
      inst_mem[tail] <= iresp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (count < CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data    = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RESET_PC), .INST_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Scoreboard: expected FIFO contents, pushed on a non-squashed response.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
  entry_t q[$];

  // Bus model state
  bit          busy     = 0;
  int          wcnt     = 0;
  int          bus_lat  = 1;
  logic [31:0] bus_addr = 32'h0;
  int          txn_cnt  = 0;
  bit          stale    = 0;
  int          done_cnt = 0;
  int          pop_cnt  = 0;
  logic [31:0] exp_pc   = RESET_PC;
  int          max_count = 0;

  // Reference model update at the clock edge, from bench-driven inputs only.
  always @(posedge clk) begin : model
    bit     popping;
    entry_t e;
    if (rst) begin
      q.delete();
      stale  = 0;
      exp_pc = RESET_PC;
    end else begin
      popping = (q.size() != 0) && out_ready && !redirect_valid;
      if (redirect_valid) begin
        q.delete();
        exp_pc = redirect_pc;
      end else begin
        if (popping) begin
          void'(q.pop_front());
          pop_cnt++;
        end
        if (iresp_data_ok && !stale) begin
          e.pc   = bus_addr;
          e.inst = bus_addr ^ KEY;
          q.push_back(e);
          exp_pc = bus_addr + 32'd4;
          done_cnt++;
        end
      end
      if (iresp_data_ok) stale = 0;
      else if (redirect_valid && busy) stale = 1;
      if (q.size() > max_count) max_count = q.size();
    end
  end

  // Bus responder and output monitor, both away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      busy          = 0;
      iresp_data_ok = 1'b0;
      wcnt          = 0;
    end else begin
      if (iresp_data_ok) begin
        iresp_data_ok = 1'b0;
        busy          = 0;
      end else if (busy) begin
        check("req_hold", 64'({ireq_valid, ireq_addr}), 64'({1'b1, bus_addr}));
        if (wcnt <= 1) begin
          iresp_data_ok = 1'b1;
          iresp_data    = bus_addr ^ KEY;
        end else begin
          wcnt--;
        end
      end
      if (!busy && ireq_valid) begin
        check("req_addr", 64'(ireq_addr), 64'(exp_pc));
        bus_addr = ireq_addr;
        busy     = 1;
        wcnt     = bus_lat;
        txn_cnt++;
      end
      check("count", 64'(count), 64'(q.size()));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("out_pc", 64'(out_pc), 64'(q[0].pc));
        check("out_inst", 64'(out_inst), 64'(q[0].inst));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  typedef struct {
    int          lat;
    bit          rnd_ready;
    bit          do_redir;
    logic [31:0] target;
    int          n_out;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vt[4];

  initial begin : main
    int  p0;
    int  d0;
    int  t0;
    bit  got;

    vt[0] = '{1, 1'b0, 1'b0, 32'h0000_0000, 8,           32'h8000_0000};
    vt[1] = '{3, 1'b1, 1'b1, 32'h8000_0100, 3*DEPTH + 1, 32'h8000_0100};
    vt[2] = '{1, 1'b1, 1'b1, 32'hFFFF_FFF8, 5,           32'hFFFF_FFF8};
    vt[3] = '{2, 1'b0, 1'b1, 32'h8000_2000, 6,           32'h8000_2000};

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    iresp_addr_ok  = 1'b0;
    repeat (3) step();
    check("rst_ireq_valid", 64'(ireq_valid), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    rst = 1'b0;

    // Streaming phases: first head after (re)start, then drain n_out entries.
    for (int i = 0; i < 4; i++) begin
      bus_lat   = vt[i].lat;
      out_ready = 1'b0;
      if (vt[i].do_redir) pulse_redirect(vt[i].target);
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        step();
        if (out_valid) begin
          got = 1;
          check("first_pc", 64'(out_pc), 64'(vt[i].exp_first));
          check("first_inst", 64'(out_inst), 64'(vt[i].exp_first ^ KEY));
        end
      end
      if (!got) timeout("first_valid");
      p0  = pop_cnt;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
        out_ready = vt[i].rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        if (pop_cnt - p0 >= vt[i].n_out) got = 1;
      end
      if (!got) timeout("stream_pops");
    end
    check("max_count", 64'(max_count <= DEPTH), 64'(1));

    // Backpressure: fill to DEPTH, then a single pop refills exactly one slot.
    bus_lat   = 1;
    out_ready = 1'b0;
    pulse_redirect(32'h8000_3000);
    d0 = done_cnt;
    repeat (40) step();
    check("full_done", 64'(done_cnt - d0), 64'(4));
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_idle", 64'(ireq_valid), 64'(0));
    p0        = pop_cnt;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (20) step();
    check("refill_pop", 64'(pop_cnt - p0), 64'(1));
    check("refill_done", 64'(done_cnt - d0), 64'(5));
    check("refill_count", 64'(count), 64'(DEPTH));
    check("refill_idle", 64'(ireq_valid), 64'(0));

    // Redirect two cycles into a slow request for 0x8000_0008.
    out_ready = 1'b1;
    bus_lat   = 5;
    pulse_redirect(32'h8000_0000);
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      step();
      if (busy && bus_addr == 32'h8000_0008 && !iresp_data_ok) got = 1;
    end
    if (!got) timeout("req_0008");
    step();
    step();
    t0 = txn_cnt;
    pulse_redirect(32'h8000_1000);
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (txn_cnt != t0) got = 1;
      else step();
    end
    if (!got) timeout("req_after_squash");
    check("squash_next_addr", 64'(ireq_addr), 64'(32'h8000_1000));
    check("squash_count", 64'(count), 64'(0));
    check("squash_out_valid", 64'(out_valid), 64'(0));

    // Redirect coincident with data_ok and a pop.
    bus_lat   = 3;
    out_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      step();
      if (iresp_data_ok && count >= 1) got = 1;
    end
    if (!got) timeout("coincident_setup");
    out_ready = 1'b1;
    pulse_redirect(32'h8000_4000);
    out_ready = 1'b0;
    check("coinc_count", 64'(count), 64'(0));
    check("coinc_out_valid", 64'(out_valid), 64'(0));
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      if (out_valid) got = 1;
    end
    if (!got) timeout("coinc_first");
    check("coinc_out_pc", 64'(out_pc), 64'(32'h8000_4000));
    check("coinc_out_inst", 64'(out_inst), 64'(32'h8000_4000 ^ KEY));

    // Asynchronous reset between edges with a request outstanding.
    bus_lat = 5;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      if (ireq_valid && count >= 1) got = 1;
    end
    if (!got) timeout("areset_setup");
    #2;
    rst = 1'b1;
    #1;
    check("areset_ireq_valid", 64'(ireq_valid), 64'(0));
    check("areset_out_valid", 64'(out_valid), 64'(0));
    check("areset_count", 64'(count), 64'(0));
    step();
    step();
    rst = 1'b0;
    t0  = txn_cnt;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      step();
      if (txn_cnt != t0) got = 1;
    end
    if (!got) timeout("areset_first_req");
    check("areset_first_addr", 64'(ireq_addr), 64'(RESET_PC));
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
